// File: rtl/code_lock_fsm.sv
// Code lock: compares a stream of symbols with a CODE_LEN-symbol code and grants or denies on confirm.
// It counts consecutive failures, enforces a timed lockout, and drops an entry after TIMEOUT idle cycles or on clear.
module code_lock_fsm #(
  parameter int SYM_W       = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sym_valid,
  input  logic [SYM_W-1:0]                  sym,
  input  logic                              confirm,
  input  logic                              clear,
  input  logic [CODE_LEN*SYM_W-1:0]         code,
  output logic                              unlock,
  output logic                              fail,
  output logic                              locked,
  output logic [$clog2(CODE_LEN+1)-1:0]     idx,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_CONF, LOCKOUT} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic           mismatch_reg, mismatch_next;
  logic [FW-1:0]  fail_cnt_reg, fail_cnt_next;
  logic [LW-1:0]  lock_reg, lock_next;
  logic [TW-1:0]  idle_reg, idle_next;
  logic           unlock_reg, unlock_next;
  logic           fail_reg, fail_next;
  logic           locked_reg, locked_next;

  logic [SYM_W-1:0] code_sym [CODE_LEN];
  logic [SYM_W-1:0] exp_sym;
  logic             sym_ok;
  logic             abort, pass_event, fail_event;

  for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_sym
    assign code_sym[gi] = code[gi*SYM_W +: SYM_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      mismatch_reg <= 1'b0;
      fail_cnt_reg <= '0;
      lock_reg     <= '0;
      idle_reg     <= '0;
      unlock_reg   <= 1'b0;
      fail_reg     <= 1'b0;
      locked_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      mismatch_reg <= mismatch_next;
      fail_cnt_reg <= fail_cnt_next;
      lock_reg     <= lock_next;
      idle_reg     <= idle_next;
      unlock_reg   <= unlock_next;
      fail_reg     <= fail_next;
      locked_reg   <= locked_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    mismatch_next = mismatch_reg;
    fail_cnt_next = fail_cnt_reg;
    lock_next     = lock_reg;
    idle_next     = idle_reg;
    unlock_next   = 1'b0;
    fail_next     = 1'b0;
    abort         = 1'b0;
    pass_event    = 1'b0;
    fail_event    = 1'b0;

    // Code symbol expected at the current entry position; idx is 0 in IDLE.
    exp_sym = code_sym[0];
    for (int k = 0; k < CODE_LEN; k++) begin
      if (idx_reg == IW'(k)) exp_sym = code_sym[k];
    end
    sym_ok = (sym == exp_sym);

    case (state_reg)
      IDLE: begin
        if (sym_valid && !confirm) begin
          mismatch_next = !sym_ok;
          idx_next      = IW'(1);
          idle_next     = '0;
          state_next    = (CODE_LEN == 1) ? WAIT_CONF : COLLECT;
        end
      end
      COLLECT: begin
        if (clear) begin
          abort = 1'b1;
        end else if (confirm) begin
          fail_event = 1'b1;
        end else if (sym_valid) begin
          mismatch_next = mismatch_reg | !sym_ok;
          idx_next      = idx_reg + IW'(1);
          idle_next     = '0;
          if (idx_reg == IW'(CODE_LEN - 1)) state_next = WAIT_CONF;
        end else if (idle_reg == TW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          idle_next = idle_reg + TW'(1);
        end
      end
      WAIT_CONF: begin
        if (clear) begin
          abort = 1'b1;
        end else if (confirm) begin
          if (mismatch_reg) fail_event = 1'b1;
          else              pass_event = 1'b1;
        end else if (sym_valid) begin
          fail_event = 1'b1;
        end else if (idle_reg == TW'(TIMEOUT - 1)) begin
          abort = 1'b1;
        end else begin
          idle_next = idle_reg + TW'(1);
        end
      end
      LOCKOUT: begin
        if (lock_reg <= LW'(1)) begin
          state_next    = IDLE;
          lock_next     = '0;
          fail_cnt_next = '0;
        end else begin
          lock_next = lock_reg - LW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort || pass_event || fail_event) begin
      state_next    = IDLE;
      idx_next      = '0;
      mismatch_next = 1'b0;
      idle_next     = '0;
    end
    if (pass_event) begin
      unlock_next   = 1'b1;
      fail_cnt_next = '0;
    end
    if (fail_event) begin
      fail_next = 1'b1;
      // The failure that reaches MAX_FAIL enters lockout directly; the counter saturates there.
      if (fail_cnt_reg >= FW'(MAX_FAIL - 1)) begin
        fail_cnt_next = FW'(MAX_FAIL);
        lock_next     = LW'(LOCK_CYCLES);
        state_next    = LOCKOUT;
      end else begin
        fail_cnt_next = fail_cnt_reg + FW'(1);
      end
    end

    locked_next = (state_next == LOCKOUT);
  end

  assign unlock   = unlock_reg;
  assign fail     = fail_reg;
  assign locked   = locked_reg;
  assign idx      = idx_reg;
  assign fail_cnt = fail_cnt_reg;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Randomized bench for code_lock_fsm: a list-based entry model predicts pulses into a queue,
// a monitor matches DUT pulses against it, and the driver checks idx/fail_cnt/locked every cycle.
module tb_code_lock_fsm;
  localparam int SYM_W       = 4;
  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int TIMEOUT     = 32;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      sym_valid = 1'b0;
  logic [SYM_W-1:0]          sym = '0;
  logic                      confirm = 1'b0;
  logic                      clear = 1'b0;
  logic [CODE_LEN*SYM_W-1:0] code = 16'hF310;
  logic                      unlock, fail, locked;
  logic [2:0]                idx;
  logic [1:0]                fail_cnt;

  code_lock_fsm #(
    .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL),
    .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym), .confirm(confirm),
    .clear(clear), .code(code), .unlock(unlock), .fail(fail), .locked(locked),
    .idx(idx), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int at; logic [1:0] kind; } ev_t;  // kind = {unlock, fail}
  ev_t exp_q[$];

  // Reference model: accepted symbols kept as a list of per-symbol match flags.
  bit m_match[$];
  int m_fails = 0;
  int m_lock  = 0;
  int m_idle  = 0;

  task automatic model_reset();
    m_match.delete();
    m_fails = 0;
    m_lock  = 0;
    m_idle  = 0;
    exp_q.delete();
  endtask

  task automatic model_fail();
    m_match.delete();
    m_fails++;
    if (m_fails >= MAX_FAIL) begin
      m_fails = MAX_FAIL;
      m_lock  = LOCK_CYCLES;
    end
    exp_q.push_back('{cyc + 1, 2'b01});
  endtask

  task automatic model_step(input bit sv, input logic [SYM_W-1:0] s, input bit cf, input bit cl);
    int pos;
    bit all_ok;
    pos = m_match.size();
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (pos == 0) begin
      if (sv && !cf) begin
        m_match.push_back(s == code[0 +: SYM_W]);
        m_idle = 0;
      end
    end else if (cl) begin
      m_match.delete();
    end else if (cf) begin
      all_ok = (pos == CODE_LEN);
      foreach (m_match[i]) if (!m_match[i]) all_ok = 0;
      if (all_ok) begin
        m_match.delete();
        m_fails = 0;
        exp_q.push_back('{cyc + 1, 2'b10});
      end else begin
        model_fail();
      end
    end else if (sv) begin
      if (pos == CODE_LEN) model_fail();
      else begin
        m_match.push_back(s == code[pos*SYM_W +: SYM_W]);
        m_idle = 0;
      end
    end else begin
      m_idle++;
      if (m_idle >= TIMEOUT) m_match.delete();
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic tick(input bit sv, input logic [SYM_W-1:0] s, input bit cf, input bit cl);
    @(negedge clk);
    sym_valid = sv; sym = s; confirm = cf; clear = cl;
    model_step(sv, s, cf, cl);
    @(posedge clk);
    #1;
    chk("idx", int'(idx), m_match.size());
    chk("fail_cnt", int'(fail_cnt), m_fails);
    chk("locked", int'(locked), (m_lock > 0) ? 1 : 0);
  endtask

  task automatic enter(input logic [15:0] seq, input bit cf);
    logic [15:0] v;
    v = seq;
    for (int k = 0; k < CODE_LEN; k++) tick(1'b1, v[k*SYM_W +: SYM_W], 1'b0, 1'b0);
    if (cf) tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: every output pulse must match the oldest predicted pulse, in kind and cycle.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (unlock || fail) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pulse_unexpected cyc=%0d actual unlock=%0b fail=%0b required none", cyc, unlock, fail);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind !== {unlock, fail} || ev.at != cyc) begin
              failures++;
              $display("FAIL pulse cyc=%0d actual unlock=%0b fail=%0b required unlock=%0b fail=%0b at cyc=%0d",
                       cyc, unlock, fail, ev.kind[1], ev.kind[0], ev.at);
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
          checks++;
          failures++;
          ev = exp_q.pop_front();
          $display("FAIL pulse_missing cyc=%0d actual none required unlock=%0b fail=%0b", cyc, ev.kind[1], ev.kind[0]);
        end
      end
    end
  end

  initial begin
    bit sv, cf, cl;
    logic [SYM_W-1:0] s;
    int pos, guard;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_unlock", int'(unlock), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    rst_n = 1'b1;
    model_reset();
    idle(3);
    tick(1'b0, '0, 1'b1, 1'b0);              // confirm alone in IDLE is ignored

    enter(16'hF310, 1'b1);                   // correct -> unlock
    enter(16'hF320, 1'b1);                   // wrong second symbol -> fail
    enter(16'hF320, 1'b1);
    enter(16'hF311, 1'b1);                   // third fail -> lockout
    enter(16'hF310, 1'b1);                   // ignored during lockout
    idle(LOCK_CYCLES);
    enter(16'hF310, 1'b1);                   // unlocks after lockout

    tick(1'b1, 4'h0, 1'b0, 1'b0);            // timeout after 0,1
    tick(1'b1, 4'h1, 1'b0, 1'b0);
    idle(TIMEOUT);
    enter(16'hF310, 1'b1);

    tick(1'b1, 4'h0, 1'b0, 1'b0);            // confirm+sym after 0,1 -> premature fail
    tick(1'b1, 4'h1, 1'b0, 1'b0);
    tick(1'b1, 4'h3, 1'b1, 1'b0);
    tick(1'b1, 4'h0, 1'b0, 1'b0);            // clear after 0,1,3
    tick(1'b1, 4'h1, 1'b0, 1'b0);
    tick(1'b1, 4'h3, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b1);
    enter(16'hF310, 1'b0);                   // over-length entry -> fail
    tick(1'b1, 4'h5, 1'b0, 1'b0);

    guard = 0;
    while (m_lock == 0 && guard < 10) begin
      enter(16'h0000, 1'b1);
      guard++;
    end
    chk("lockout_reached", (m_lock > 0) ? 1 : 0, 1);
    idle(5);
    @(negedge clk);
    #2 rst_n = 1'b0;                          // asynchronous, between clock edges
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_fail_cnt", int'(fail_cnt), 0);
    chk("async_idx", int'(idx), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enter(16'hF310, 1'b1);

    // Randomized traffic, biased towards correct symbols so unlocks occur
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(299) == 0) code = 16'($urandom);
      if ($urandom_range(99) == 0) begin
        idle(TIMEOUT + 1);
      end else begin
        pos = m_match.size();
        sv  = ($urandom_range(99) < 55);
        cf  = ($urandom_range(99) < 10);
        cl  = ($urandom_range(99) < 3);
        if (pos < CODE_LEN && $urandom_range(9) < 8) s = code[pos*SYM_W +: SYM_W];
        else s = 4'($urandom);
        tick(sv, s, cf, cl);
      end
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
